load_store_unit: RTL and testbench

Requester-side master for the single-cycle processor's word-addressed data memory port (addr, wdata, MemWrite, rdata). Accepts byte-addressed load/store requests from the datapath over a valid/ready handshake. Converts them into word-index memory accesses, doing read-modify-write for byte and halfword stores. Returns sign- or zero-extended load data, or an error for misaligned or out-of-range accesses.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 76 +++++++
 tb/tb_load_store_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: datapath request/response handshake plus word-addressed data memory port
//   req_*  : byte-addressed load/store request with valid/ready handshake
//   resp_* : single-cycle response pulse with load data and error flag
//   mem_*  : word-index memory access (combinational read, write committed on rising clk)
//   master : the load/store unit's view; slave : the datapath/memory side
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic [31:0] mem_rdata;
   modport master (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write
   );
   modport slave (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store requester for a word-addressed data memory
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.master (request/response handshake and memory port)
//   DEPTH : number of 32-bit words in the memory; larger word indices are errors
module load_store_unit #(
   parameter int DEPTH = 32
) (
   input logic               clk,
   input logic               rst_n,
   load_store_unit_if.master bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
   state_t      state;
   logic        wr_q, sgn_q, err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, old_q, rdata_q;
   logic        err;
   logic [4:0]  bsh, hsh;
   logic [31:0] lane, merged, ld;
   always_comb begin
      err = bus.req_size == 2'b11 ||
            (bus.req_size == 2'b01 && bus.req_addr[0]) ||
            (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
            {2'b00, bus.req_addr[31:2]} >= 32'(DEPTH);
      bsh = {addr_q[1:0], 3'b000};
      hsh = {addr_q[1], 4'b0000};
      // halfword accesses are 2-byte aligned here, so the byte shift also selects the halfword lane
      lane = bus.mem_rdata >> bsh;
      ld = size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane[7:0]} :
           size_q == 2'b01 ? {{16{sgn_q & lane[15]}}, lane[15:0]} : bus.mem_rdata;
      merged = size_q == 2'b00 ? (old_q & ~(32'hFF << bsh)) | ({24'h0, wdata_q[7:0]} << bsh) :
                                 (old_q & ~(32'hFFFF << hsh)) | ({16'h0, wdata_q[15:0]} << hsh);
   end
   // outputs decode straight from the state register so reset clears them immediately
   assign bus.req_ready  = state == IDLE && rst_n;
   assign bus.resp_valid = state == RESP;
   assign bus.resp_rdata = state == RESP ? rdata_q : 32'h0;
   assign bus.resp_err   = state == RESP && err_q;
   assign bus.mem_addr   = (state == READ || state == WRITE) ? {2'b00, addr_q[31:2]} : 32'h0;
   assign bus.mem_write  = state == WRITE;
   assign bus.mem_wdata  = state == WRITE ? (size_q == 2'b10 ? wdata_q : merged) : 32'h0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         wr_q    <= 1'b0;
         sgn_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         old_q   <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               wr_q    <= bus.req_write;
               sgn_q   <= bus.req_signed;
               size_q  <= bus.req_size;
               addr_q  <= bus.req_addr;
               wdata_q <= bus.req_wdata;
               err_q   <= err;
               rdata_q <= 32'h0;
               state   <= err ? RESP : (bus.req_write && bus.req_size == 2'b10) ? WRITE : READ;
            end
            READ: begin
               if (wr_q) old_q <= bus.mem_rdata;
               else rdata_q <= ld;
               state <= wr_q ? WRITE : RESP;
            end
            WRITE: state <= RESP;
            RESP: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a 32-word memory model
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   load_store_unit_if bus();
   load_store_unit #(.DEPTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
   always #5 clk = ~clk;
   logic [31:0] mem [32];
   logic        seeded = 1'b0;
   int          n_cmp = 0, n_err = 0, wcnt = 0, rvcnt = 0;
   logic [31:0] waddr = 32'h0, wdat = 32'h0;
   assign bus.mem_rdata = bus.mem_addr < 32 ? mem[bus.mem_addr[4:0]] : 32'h0;
   always @(posedge clk) begin
      if (!rst_n && !seeded) begin
         for (int i = 0; i < 32; i++) mem[i] <= i;
         seeded <= 1'b1;
      end else if (bus.mem_write) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
   end
   always @(negedge clk) begin
      if (bus.mem_write) begin
         wcnt++;
         waddr = bus.mem_addr;
         wdat = bus.mem_wdata;
      end
      if (bus.resp_valid) rvcnt++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic xact(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
      int n;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
      bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = d;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.resp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      rd = bus.resp_rdata;
      er = bus.resp_err;
   endtask
   logic [31:0] rd;
   logic        er;
   int          lat, w0, r0;
   initial begin
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
      bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready), 32'd1);
      xact(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
      chk("lw14_data", rd, 32'h5);
      chk("lw14_err", 32'(er), 32'd0);
      chk("lw14_lat", 32'(lat), 32'd2);
      chk("lw14_nowrite", 32'(wcnt), 32'd0);
      xact(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, rd, er, lat);
      chk("sw08_wcnt", 32'(wcnt), 32'd1);
      chk("sw08_addr", waddr, 32'd2);
      chk("sw08_wdata", wdat, 32'hDEADBEEF);
      chk("sw08_lat", 32'(lat), 32'd2);
      chk("sw08_rdata", rd, 32'h0);
      xact(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, rd, er, lat);
      chk("lw08_data", rd, 32'hDEADBEEF);
      xact(1'b1, 2'b00, 1'b0, 32'h0D, 32'h80, rd, er, lat);
      chk("sb0d_wcnt", 32'(wcnt), 32'd2);
      chk("sb0d_addr", waddr, 32'd3);
      chk("sb0d_wdata", wdat, 32'h00008003);
      chk("sb0d_lat", 32'(lat), 32'd3);
      xact(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, rd, er, lat);
      chk("lb0d", rd, 32'hFFFFFF80);
      xact(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, rd, er, lat);
      chk("lbu0d", rd, 32'h00000080);
      xact(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0, rd, er, lat);
      chk("lh0c", rd, 32'hFFFF8003);
      xact(1'b1, 2'b01, 1'b0, 32'h0E, 32'hA5A5, rd, er, lat);
      chk("sh0e_wdata", wdat, 32'hA5A58003);
      xact(1'b0, 2'b01, 1'b0, 32'h0E, 32'h0, rd, er, lat);
      chk("lhu0e", rd, 32'h0000A5A5);
      w0 = wcnt;
      xact(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234, rd, er, lat);
      chk("sh03_err", 32'(er), 32'd1);
      chk("sh03_lat", 32'(lat), 32'd1);
      chk("sh03_rdata", rd, 32'h0);
      xact(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd, er, lat);
      chk("lw80_err", 32'(er), 32'd1);
      chk("lw80_rdata", rd, 32'h0);
      xact(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, rd, er, lat);
      chk("size11_err", 32'(er), 32'd1);
      xact(1'b1, 2'b10, 1'b0, 32'h06, 32'h0, rd, er, lat);
      chk("sw06_err", 32'(er), 32'd1);
      chk("err_nowrite", 32'(wcnt), 32'(w0));
      xact(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, rd, er, lat);
      chk("lw7c_err", 32'(er), 32'd0);
      chk("lw7c_data", rd, 32'd31);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h0;
      chk("b2b_rdy0", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      chk("b2b_read_rdy", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      chk("b2b_resp1_v", 32'(bus.resp_valid), 32'd1);
      chk("b2b_resp1", bus.resp_rdata, 32'h0);
      chk("b2b_resp_rdy", 32'(bus.req_ready), 32'd0);
      bus.req_addr = 32'h04;
      @(negedge clk);
      chk("b2b_idle_rdy", 32'(bus.req_ready), 32'd1);
      chk("b2b_idle_v", 32'(bus.resp_valid), 32'd0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_read2_rdy", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      chk("b2b_resp2_v", 32'(bus.resp_valid), 32'd1);
      chk("b2b_resp2", bus.resp_rdata, 32'h1);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
      bus.req_addr = 32'h10; bus.req_wdata = 32'hAB;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("rw_mem_write", 32'(bus.mem_write), 32'd1);
      w0 = wcnt;
      r0 = rvcnt;
      rst_n = 1'b0;
      #1;
      chk("rw_write_drop", 32'(bus.mem_write), 32'd0);
      chk("rw_addr_drop", bus.mem_addr, 32'h0);
      chk("rw_ready_low", 32'(bus.req_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rw_no_resp", 32'(rvcnt), 32'(r0));
      chk("rw_no_commit", 32'(wcnt), 32'(w0));
      chk("rw_ready", 32'(bus.req_ready), 32'd1);
      xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
      chk("rw_word4", rd, 32'h4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
